// File: rtl/scoreboard_hazard_unit.sv
// rtl/scoreboard_hazard_unit.sv - 5-stage pipeline hazard unit: bypass selects, load-use stall,
// mult/div handshake FSM with timeout, saturating stall-cycle counter.
module scoreboard_hazard_unit #(
  parameter int REG_W      = 5,
  parameter int EXC_REG    = 30,
  parameter int LINK_REG   = 31,
  parameter int MD_TIMEOUT = 64,
  parameter int PERF_W     = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       fd_instr,
  input  logic [31:0]       dx_instr,
  input  logic [31:0]       xm_instr,
  input  logic [31:0]       wb_instr,
  input  logic              xm_err,
  input  logic              wb_err,
  input  logic              md_ready,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              wb_from_mem,
  output logic              stall_fd,
  output logic              stall_dx,
  output logic              bubble_dx,
  output logic              md_start,
  output logic              md_busy,
  output logic              md_timeout,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int CW = $clog2(MD_TIMEOUT);

  localparam logic [4:0] OP_R    = 5'd0;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;
  localparam logic [4:0] OP_SETX = 5'd21;
  localparam logic [4:0] OP_BEX  = 5'd22;
  localparam logic [4:0] ALU_MUL = 5'd6;
  localparam logic [4:0] ALU_DIV = 5'd7;

  localparam logic [REG_W-1:0] EXC  = REG_W'(EXC_REG);
  localparam logic [REG_W-1:0] LINK = REG_W'(LINK_REG);

  // Register reference packed as {valid, index}
  typedef logic [REG_W:0] ref_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  function automatic ref_t dest_of(input logic [4:0] op, input logic [REG_W-1:0] rd);
    logic             v;
    logic [REG_W-1:0] r;
    v = 1'b0;
    r = rd;
    case (op)
      OP_R, OP_ADDI, OP_LW: v = 1'b1;
      OP_JAL:  begin v = 1'b1; r = LINK; end
      OP_SETX: begin v = 1'b1; r = EXC;  end
      default: v = 1'b0;
    endcase
    return {v && (r != '0), r};
  endfunction

  function automatic ref_t src_a_of(input logic [4:0] op, input logic [REG_W-1:0] rd,
                                    input logic [REG_W-1:0] rs);
    ref_t s;
    s = '0;
    case (op)
      OP_R, OP_ADDI, OP_LW, OP_SW: s = {1'b1, rs};
      OP_BNE, OP_BLT, OP_JR:       s = {1'b1, rd};
      OP_BEX:                      s = {1'b1, EXC};
      default:                     s = '0;
    endcase
    return s;
  endfunction

  function automatic ref_t src_b_of(input logic [4:0] op, input logic [REG_W-1:0] rd,
                                    input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt);
    ref_t s;
    s = '0;
    case (op)
      OP_R:           s = {1'b1, rt};
      OP_SW:          s = {1'b1, rd};
      OP_BNE, OP_BLT: s = {1'b1, rs};
      default:        s = '0;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] fsel(input ref_t src, input ref_t xm_d, input logic xm_lw,
                                      input ref_t wb_d, input logic err);
    logic [1:0] sel;
    sel = 2'd0;
    if (src[REG_W]) begin
      if (src[REG_W-1:0] == EXC && err)
        sel = 2'd3;
      else if (xm_d[REG_W] && !xm_lw && xm_d[REG_W-1:0] == src[REG_W-1:0])
        sel = 2'd1;
      else if (wb_d[REG_W] && wb_d[REG_W-1:0] == src[REG_W-1:0])
        sel = 2'd2;
    end
    return sel;
  endfunction

  logic [4:0]       fd_op, dx_op, xm_op, wb_op, dx_alu;
  logic [REG_W-1:0] fd_rd, fd_rs, fd_rt, dx_rd, dx_rs, dx_rt, xm_rd, wb_rd;
  ref_t             fd_a, fd_b, dx_a, dx_b, dx_d, xm_d, wb_d;
  logic             unused_bits;

  assign fd_op  = fd_instr[31:27];
  assign fd_rd  = fd_instr[26 -: REG_W];
  assign fd_rs  = fd_instr[21 -: REG_W];
  assign fd_rt  = fd_instr[16 -: REG_W];
  assign dx_op  = dx_instr[31:27];
  assign dx_rd  = dx_instr[26 -: REG_W];
  assign dx_rs  = dx_instr[21 -: REG_W];
  assign dx_rt  = dx_instr[16 -: REG_W];
  assign dx_alu = dx_instr[6:2];
  assign xm_op  = xm_instr[31:27];
  assign xm_rd  = xm_instr[26 -: REG_W];
  assign wb_op  = wb_instr[31:27];
  assign wb_rd  = wb_instr[26 -: REG_W];

  assign unused_bits = ^{fd_instr[11:0], dx_instr[11:7], dx_instr[1:0],
                         xm_instr[21:0], wb_instr[21:0]};

  assign fd_a = src_a_of(fd_op, fd_rd, fd_rs);
  assign fd_b = src_b_of(fd_op, fd_rd, fd_rs, fd_rt);
  assign dx_a = src_a_of(dx_op, dx_rd, dx_rs);
  assign dx_b = src_b_of(dx_op, dx_rd, dx_rs, dx_rt);
  assign dx_d = dest_of(dx_op, dx_rd);
  assign xm_d = dest_of(xm_op, xm_rd);
  assign wb_d = dest_of(wb_op, wb_rd);

  assign fwd_a_sel   = fsel(dx_a, xm_d, xm_op == OP_LW, wb_d, xm_err | wb_err);
  assign fwd_b_sel   = fsel(dx_b, xm_d, xm_op == OP_LW, wb_d, xm_err | wb_err);
  assign wb_from_mem = (wb_op == OP_LW);

  // Control outputs stay quiet on the cycle right after a reset edge,
  // even if the latches still hold a triggering instruction.
  logic rst_q, quiet;
  always_ff @(posedge clock) begin
    if (!reset_n) rst_q <= 1'b1;
    else          rst_q <= 1'b0;
  end
  assign quiet = rst_q || !reset_n;

  logic lu_flag, lu_hit, lu_trig;
  assign lu_hit = (dx_op == OP_LW) && dx_d[REG_W] &&
                  ((fd_a[REG_W] && fd_a[REG_W-1:0] == dx_d[REG_W-1:0]) ||
                   (fd_b[REG_W] && fd_b[REG_W-1:0] == dx_d[REG_W-1:0]));
  assign lu_trig = lu_hit && !lu_flag && !quiet;

  always_ff @(posedge clock) begin
    if (!reset_n) lu_flag <= 1'b0;
    else          lu_flag <= lu_trig;
  end

  md_state_t      state, next_state;
  logic [CW-1:0]  md_cnt;
  logic           dx_md, cnt_last, md_stall;

  assign dx_md    = (dx_op == OP_R) && (dx_alu == ALU_MUL || dx_alu == ALU_DIV);
  assign cnt_last = (md_cnt == CW'(MD_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (dx_md && !quiet) next_state = BUSY;
      BUSY:    if (md_ready) next_state = DONE;
               else if (cnt_last) next_state = IDLE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The start cycle also stalls: the mul/div must stay in DX while the unit runs.
  always_comb begin
    md_start   = 1'b0;
    md_timeout = 1'b0;
    md_stall   = 1'b0;
    case (state)
      IDLE: if (dx_md && !quiet) begin
        md_start = 1'b1;
        md_stall = 1'b1;
      end
      BUSY: begin
        md_stall   = 1'b1;
        md_timeout = !md_ready && cnt_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n)           md_cnt <= '0;
    else if (md_start)      md_cnt <= '0;
    else if (state == BUSY) md_cnt <= md_cnt + CW'(1);
  end

  assign md_busy   = (state != IDLE);
  assign stall_fd  = lu_trig | md_stall;
  assign stall_dx  = md_stall;
  assign bubble_dx = lu_trig && (state != BUSY);

  always_ff @(posedge clock) begin
    if (!reset_n)
      stall_cycles <= '0;
    else if (stall_fd && stall_cycles != '1)
      stall_cycles <= stall_cycles + PERF_W'(1);
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// tb/tb_scoreboard_hazard_unit.sv - directed bench for scoreboard_hazard_unit with an
// expected-output queue filled at drive time and drained at each sample point.
module tb_scoreboard_hazard_unit;

  logic        clock, reset_n;
  logic [31:0] fd_instr, dx_instr, xm_instr, wb_instr;
  logic        xm_err, wb_err, md_ready;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        wb_from_mem, stall_fd, stall_dx, bubble_dx, md_start, md_busy, md_timeout;
  logic [3:0]  stall_cycles;

  int total = 0;
  int bad   = 0;

  string       tag_q[$];
  logic [10:0] exp_q[$];

  localparam logic [31:0] NOP = 32'd0;

  scoreboard_hazard_unit #(.MD_TIMEOUT(8), .PERF_W(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .fd_instr(fd_instr), .dx_instr(dx_instr), .xm_instr(xm_instr), .wb_instr(wb_instr),
    .xm_err(xm_err), .wb_err(wb_err), .md_ready(md_ready),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .wb_from_mem(wb_from_mem),
    .stall_fd(stall_fd), .stall_dx(stall_dx), .bubble_dx(bubble_dx),
    .md_start(md_start), .md_busy(md_busy), .md_timeout(md_timeout),
    .stall_cycles(stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] r_type(input int rd, input int rs, input int rt, input int alu);
    return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(alu), 2'b00};
  endfunction

  function automatic logic [31:0] i_type(input int op, input int rd, input int rs);
    return {5'(op), 5'(rd), 5'(rs), 17'd0};
  endfunction

  // {fwd_a, fwd_b, wb_from_mem, stall_fd, stall_dx, bubble_dx, md_start, md_busy, md_timeout}
  function automatic logic [10:0] ev(input int fa, input int fb, input bit wfm, input bit sfd,
                                     input bit sdx, input bit bub, input bit st, input bit bz,
                                     input bit tm);
    return {2'(fa), 2'(fb), wfm, sfd, sdx, bub, st, bz, tm};
  endfunction

  task automatic check_out();
    string       t;
    logic [10:0] e, o;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    o = {fwd_a_sel, fwd_b_sel, wb_from_mem, stall_fd, stall_dx, bubble_dx,
         md_start, md_busy, md_timeout};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", t, o, e);
    end
  endtask

  task automatic check_cnt(input string t, input logic [3:0] e);
    total++;
    assert (stall_cycles === e) else begin
      bad++;
      $error("FAIL %s stall_cycles observed=%0d expected=%0d", t, stall_cycles, e);
    end
  endtask

  task automatic drive(input logic [31:0] f, input logic [31:0] d, input logic [31:0] x,
                       input logic [31:0] w, input logic xe, input logic we, input logic rdy,
                       input string t, input logic [10:0] e);
    @(posedge clock);
    #1;
    reset_n  = 1'b1;
    fd_instr = f;
    dx_instr = d;
    xm_instr = x;
    wb_instr = w;
    xm_err   = xe;
    wb_err   = we;
    md_ready = rdy;
    tag_q.push_back(t);
    exp_q.push_back(e);
    #3;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] busy_v, start_v, zero_v;
    logic [31:0] mul_i, div_i, use_a, use_b;
    busy_v  = ev(0, 0, 0, 1, 1, 0, 0, 1, 0);
    start_v = ev(0, 0, 0, 1, 1, 0, 1, 0, 0);
    zero_v  = ev(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mul_i   = r_type(8, 1, 2, 6);
    div_i   = r_type(9, 1, 2, 7);
    use_a   = r_type(7, 4, 1, 0);
    use_b   = r_type(7, 1, 4, 0);

    reset_n = 1'b0;
    fd_instr = NOP; dx_instr = NOP; xm_instr = NOP; wb_instr = NOP;
    xm_err = 1'b0; wb_err = 1'b0; md_ready = 1'b0;
    repeat (2) @(posedge clock);

    drive(NOP, NOP, NOP, NOP, 0, 0, 0, "reset_outputs", zero_v);
    check_cnt("reset_count", 4'd0);

    // Bypass priority and decode coverage
    drive(NOP, r_type(6, 5, 5, 0), r_type(5, 1, 2, 0), r_type(5, 3, 4, 0), 0, 0, 0,
          "xm_beats_wb", ev(1, 1, 0, 0, 0, 0, 0, 0, 0));
    drive(NOP, r_type(6, 5, 5, 0), NOP, r_type(5, 3, 4, 0), 0, 0, 0,
          "wb_only", ev(2, 2, 0, 0, 0, 0, 0, 0, 0));
    drive(NOP, r_type(6, 5, 5, 0), i_type(8, 5, 1), r_type(5, 3, 4, 0), 0, 0, 0,
          "xm_lw_no_bypass", ev(2, 2, 0, 0, 0, 0, 0, 0, 0));
    drive(NOP, r_type(3, 0, 0, 0), r_type(0, 1, 2, 0), r_type(0, 1, 2, 0), 0, 0, 0,
          "r0_no_hazard", zero_v);
    drive(NOP, i_type(22, 0, 0), NOP, NOP, 1, 0, 0,
          "bex_exc_err", ev(3, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(NOP, i_type(22, 0, 0), i_type(21, 0, 0), NOP, 0, 0, 0,
          "bex_from_setx", ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(NOP, i_type(7, 9, 2), NOP, i_type(8, 9, 1), 0, 0, 0,
          "sw_b_from_wb_lw", ev(0, 2, 1, 0, 0, 0, 0, 0, 0));
    drive(NOP, i_type(4, 31, 0), i_type(3, 0, 0), NOP, 0, 0, 0,
          "jr_from_jal", ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(NOP, i_type(2, 3, 4), r_type(4, 1, 1, 0), r_type(3, 1, 1, 0), 0, 0, 0,
          "bne_operands", ev(2, 1, 0, 0, 0, 0, 0, 0, 0));

    // Load-use stall
    drive(use_a, i_type(8, 4, 2), NOP, NOP, 0, 0, 0,
          "lu_stall", ev(0, 0, 0, 1, 0, 1, 0, 0, 0));
    drive(use_a, NOP, i_type(8, 4, 2), NOP, 0, 0, 0, "lu_released", zero_v);
    drive(NOP, use_a, NOP, i_type(8, 4, 2), 0, 0, 0,
          "lu_fwd_mem", ev(2, 0, 1, 0, 0, 0, 0, 0, 0));
    drive(use_b, i_type(8, 4, 2), NOP, NOP, 0, 0, 0,
          "lu_stall_b", ev(0, 0, 0, 1, 0, 1, 0, 0, 0));
    drive(use_b, i_type(8, 4, 2), NOP, NOP, 0, 0, 0, "lu_retrigger_blocked", zero_v);
    drive(r_type(7, 0, 0, 0), i_type(8, 0, 2), NOP, NOP, 0, 0, 0, "lu_r0", zero_v);
    check_cnt("count_after_lu", 4'd2);

    // Mult with md_ready five cycles after start
    drive(NOP, mul_i, NOP, NOP, 0, 0, 0, "mul_start", start_v);
    drive(NOP, mul_i, NOP, NOP, 0, 0, 0, "mul_busy1", busy_v);
    drive(NOP, mul_i, NOP, NOP, 0, 0, 0, "mul_busy2", busy_v);
    drive(use_a, i_type(8, 4, 2), NOP, NOP, 0, 0, 0, "busy_lu_no_bubble", busy_v);
    drive(NOP, mul_i, NOP, NOP, 0, 0, 0, "mul_busy4", busy_v);
    drive(NOP, mul_i, NOP, NOP, 0, 0, 1, "mul_ready", busy_v);
    drive(NOP, mul_i, NOP, NOP, 0, 0, 0, "mul_done", ev(0, 0, 0, 0, 0, 0, 0, 1, 0));
    drive(NOP, NOP, NOP, NOP, 0, 0, 1, "mul_idle_ready_ignored", zero_v);
    check_cnt("count_after_mul", 4'd8);
    drive(NOP, NOP, NOP, NOP, 0, 0, 0, "mul_stays_idle", zero_v);

    // Div timing out; the 4-bit counter saturates along the way
    drive(NOP, div_i, NOP, NOP, 0, 0, 0, "div_start", start_v);
    for (int i = 1; i <= 7; i++)
      drive(NOP, div_i, NOP, NOP, 0, 0, 0, $sformatf("div_busy%0d", i), busy_v);
    drive(NOP, div_i, NOP, NOP, 0, 0, 0, "div_timeout", ev(0, 0, 0, 1, 1, 0, 0, 1, 1));
    drive(NOP, NOP, NOP, NOP, 0, 0, 0, "div_idle", zero_v);
    check_cnt("count_saturated", 4'd15);

    // Reset in the middle of BUSY
    drive(NOP, mul_i, NOP, NOP, 0, 0, 0, "rst_mul_start", start_v);
    drive(NOP, mul_i, NOP, NOP, 0, 0, 0, "rst_mul_busy", busy_v);
    @(posedge clock);
    #1;
    reset_n  = 1'b0;
    dx_instr = NOP;
    drive(NOP, NOP, NOP, NOP, 0, 0, 0, "rst_idle", zero_v);
    check_cnt("rst_count_clear", 4'd0);
    drive(NOP, NOP, NOP, NOP, 0, 0, 1, "rst_late_ready", zero_v);
    drive(NOP, NOP, NOP, NOP, 0, 0, 0, "rst_still_idle", zero_v);
    check_cnt("rst_count_still_clear", 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
